pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Sequential partner of the combinational next-PC unit. Owns the architectural PC register and feeds `pc` to the next-PC logic.
- Fetches the instruction at `pc` from instruction memory over a req/gnt/rvalid handshake, then holds it for decode.
- When decode retires the held instruction, loads the next-PC result back into `pc`.
- Sits between the next-PC unit, instruction memory and the decode stage of the multi-cycle P4 datapath.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- IMEM_BASE, 32'h0000_3000, lowest legal fetch address.
- IMEM_WORDS, 4096, number of legal 32-bit words starting at IMEM_BASE.
- TIMEOUT_CYCLES, 16, watchdog limit in S_WAIT (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- npc_in  input  32  next PC from the next-PC unit.
- instr_ready  input  1  decode retires the held instruction this cycle.
- imem_gnt  input  1  instruction memory accepts the request.
- imem_rvalid  input  1  instruction memory read data valid.
- imem_rdata  input  32  instruction word.
- pc  output  32  current PC, drives the next-PC unit and decode.
- imem_req  output  1  fetch request, registered.
- imem_addr  output  32  fetch address; always equals `pc`.
- instr  output  32  held instruction.
- instr_valid  output  1  `instr` is valid for decode.
- fetch_err  output  1  sticky fault flag.
- err_code  output  2  01 misaligned, 10 out of range, 11 timeout, 00 none.
- retire_cnt  output  32  count of retired instructions.

Behaviour:
- Interface decision: one clock, `clk`; reset is asynchronous and active-low, on port `reset`.
- Reset values while `reset` is 0, regardless of state:
  - pc = RESET_PC; state = S_IDLE
  - imem_req = 0; instr = 0; instr_valid = 0
  - fetch_err = 0; err_code = 00; retire_cnt = 0
  - Any in-flight fetch is abandoned; an imem_rvalid arriving after reset deassertion in S_IDLE/S_REQ is ignored.
- FSM states: S_IDLE, S_REQ, S_WAIT, S_HOLD, S_ERR.
- S_IDLE: go to S_REQ on the next edge; imem_req rises to 1 in that same edge.
- S_REQ: imem_req = 1. On imem_gnt: imem_req <= 0, go to S_WAIT. Hold the request indefinitely without gnt.
- S_WAIT: on imem_rvalid: instr <= imem_rdata, instr_valid <= 1, go to S_HOLD. imem_gnt is ignored in S_WAIT.
- S_HOLD: instr and instr_valid are held stable until instr_ready. On instr_ready:
  - instr_valid <= 0; retire_cnt <= retire_cnt + 1, wrapping from 32'hFFFF_FFFF to 0.
  - Check npc_in:
    - npc_in[1:0] != 0: go to S_ERR, code 01.
    - npc_in < IMEM_BASE or npc_in >= IMEM_BASE + 4*IMEM_WORDS: go to S_ERR, code 10.
    - otherwise: pc <= npc_in, imem_req <= 1, go to S_REQ.
  - Misalignment takes priority over the range check.
- The PC changes only on a retire edge.
- Minimum latency with gnt and rvalid each one cycle after request: 3 cycles per instruction (REQ, WAIT, HOLD).
- imem_gnt and imem_rvalid asserted together in S_REQ: only the gnt is used; the state still passes through S_WAIT, which then waits for a new rvalid.
- S_ERR: fetch_err = 1 and err_code are held; pc is held at the last legal value; imem_req = 0; instr_valid = 0. Only reset leaves S_ERR.
- A self-loop, npc_in == pc, is legal and refetches the same word.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A 5-bit watchdog counter clears on entry to S_WAIT and increments each cycle in S_WAIT without rvalid.
  - When the count reaches TIMEOUT_CYCLES: go to S_ERR, code 11.
  - rvalid on the same cycle the count hits the limit wins: normal capture, no error.
- Not defined: no counter; S_WAIT waits forever; code 11 is never produced.

Test Plan:
- Reset release, gnt and rvalid 1 cycle after each request, rdata 32'h3C01_1234 -> imem_addr 0x3000; instr_valid high on cycle 3; instr_ready with npc_in 0x3004 -> pc 0x3004, retire_cnt 1.
- Ten back-to-back retires with npc_in = pc+4 -> pc 0x3028, retire_cnt 10, one instruction every 3 cycles.
- In S_HOLD, npc_in 0x3002 -> fetch_err 1, err_code 01, pc stays 0x3000; npc_in 0x2FFC -> err_code 10.
- gnt delayed 5 cycles, rvalid delayed 7 cycles, instr_ready delayed 4 cycles -> imem_req held high and instr stable throughout; no lost or duplicate retire.
- Assert reset in S_WAIT, then send rvalid 1 cycle after release -> rvalid ignored; pc 0x3000; a fresh request is issued.
- With FETCH_TIMEOUT_EN, no rvalid for 16 cycles -> err_code 11. Without the macro -> still in S_WAIT after 100 cycles.

Source files
------------

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory fetch bus: request/grant plus read-data-valid return.
interface pc_fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    // Fetch controller side
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    // Instruction memory side
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: owns the architectural PC, fetches the word at pc over the
// imem req/gnt/rvalid handshake, holds it for decode and loads npc_in on retire.
// Optional build macro FETCH_TIMEOUT_EN adds an S_WAIT watchdog (err_code 11).
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC       = 32'h0000_3000,
    parameter logic [31:0] IMEM_BASE      = 32'h0000_3000,
    parameter int unsigned IMEM_WORDS     = 4096,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset,
    pc_fetch_ctrl_if.master    imem,
    input  logic [31:0]        npc_in,
    input  logic               instr_ready,
    output logic [31:0]        pc,
    output logic [31:0]        instr,
    output logic               instr_valid,
    output logic               fetch_err,
    output logic [1:0]         err_code,
    output logic [31:0]        retire_cnt
);

    // One past the last legal byte address; 33 bits so the sum cannot wrap
    localparam logic [32:0] IMEM_LIMIT = 33'(IMEM_BASE) + (33'(IMEM_WORDS) << 2);

    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;

    // Watchdog limit must fit the 5-bit counter
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 31) begin : g_bad_timeout
        $error("pc_fetch_ctrl: TIMEOUT_CYCLES must be in 1..31");
    end

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_ERR  = 3'd4
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic        req_q;
    logic [31:0] instr_q;
    logic        valid_q;
    logic        err_q;
    logic [1:0]  code_q;
    logic [31:0] retire_q;

    logic        npc_misaligned_c;
    logic        npc_out_of_range_c;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [4:0] WD_LAST = 5'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;
    logic [4:0] wd_q;
`endif

    // Legality of the next PC presented at retire time
    assign npc_misaligned_c   = (npc_in[1:0] != 2'b00);
    assign npc_out_of_range_c = (npc_in < IMEM_BASE) || ({1'b0, npc_in} >= IMEM_LIMIT);

    // Fetch sequencer: state, PC, request, held instruction, fault and retire count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            req_q    <= 1'b0;
            instr_q  <= 32'h0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= 2'b00;
            retire_q <= 32'h0;
`ifdef FETCH_TIMEOUT_EN
            wd_q     <= 5'd0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    req_q   <= 1'b1;
                    state_q <= S_REQ;
                end
                S_REQ: begin
                    // Any rvalid seen here belongs to no request of ours
                    if (imem.imem_gnt) begin
                        req_q   <= 1'b0;
                        state_q <= S_WAIT;
`ifdef FETCH_TIMEOUT_EN
                        wd_q    <= 5'd0;
`endif
                    end
                end
                S_WAIT: begin
                    if (imem.imem_rvalid) begin
                        instr_q <= imem.imem_rdata;
                        valid_q <= 1'b1;
                        state_q <= S_HOLD;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (wd_q == WD_LAST) begin
                        err_q   <= 1'b1;
                        code_q  <= ERR_TIMEOUT;
                        state_q <= S_ERR;
                    end else begin
                        wd_q <= wd_q + 5'd1;
                    end
`endif
                end
                S_HOLD: begin
                    if (instr_ready) begin
                        valid_q  <= 1'b0;
                        retire_q <= retire_q + 32'd1;
                        if (npc_misaligned_c) begin
                            err_q   <= 1'b1;
                            code_q  <= ERR_MISALIGN;
                            state_q <= S_ERR;
                        end else if (npc_out_of_range_c) begin
                            err_q   <= 1'b1;
                            code_q  <= ERR_RANGE;
                            state_q <= S_ERR;
                        end else begin
                            pc_q    <= npc_in;
                            req_q   <= 1'b1;
                            state_q <= S_REQ;
                        end
                    end
                end
                S_ERR: begin
                    // Terminal until reset; everything already parked
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
                default: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign pc             = pc_q;
    assign instr          = instr_q;
    assign instr_valid    = valid_q;
    assign fetch_err      = err_q;
    assign err_code       = code_q;
    assign retire_cnt     = retire_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: handshake-level reference model, memory/decode
// responder with delay knobs, per-cycle compare and directed literal checks.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] BASE     = 32'h0000_3000;
    localparam int unsigned WORDS    = 4096;
    localparam int          TMO      = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [31:0] npc;
    logic        rdy;
    logic [31:0] pc, instr, retire_cnt;
    logic        instr_valid, fetch_err;
    logic [1:0]  err_code;

    pc_fetch_ctrl_if bus ();

    pc_fetch_ctrl #(
        .RESET_PC       (RESET_PC),
        .IMEM_BASE      (BASE),
        .IMEM_WORDS     (WORDS),
        .TIMEOUT_CYCLES (TMO)
    ) u_dut (
        .clk         (clk),
        .reset       (rst_n),
        .imem        (bus),
        .npc_in      (npc),
        .instr_ready (rdy),
        .pc          (pc),
        .instr       (instr),
        .instr_valid (instr_valid),
        .fetch_err   (fetch_err),
        .err_code    (err_code),
        .retire_cnt  (retire_cnt)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Stimulus knobs
    int          gnt_dly, rv_dly, rdy_dly;
    bit          retire_en, npc_fixed_en, rv_force;
    logic [31:0] npc_fix;

    // Reference model: what the fetch unit is waiting for, as handshake flags
    logic        m_started, m_req, m_wait, m_valid, m_err;
    logic [1:0]  m_code;
    logic [31:0] m_pc, m_instr, m_cnt;
    int          ph;

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return (a == 32'h0000_3000) ? 32'h3C01_1234 : ((a ^ 32'h5A00_0000) + 32'h11);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    endtask

    // Model advances on the same edges as the DUT, from bench-driven inputs only
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_started <= 1'b0; m_req <= 1'b0; m_wait <= 1'b0; m_valid <= 1'b0;
            m_err <= 1'b0; m_code <= 2'b00; m_pc <= RESET_PC; m_instr <= 32'h0;
            m_cnt <= 32'h0; ph <= 0;
        end else if (!m_started) begin
            m_started <= 1'b1; m_req <= 1'b1; ph <= 0;
        end else if (m_err) begin
            ph <= ph;
        end else if (m_req) begin
            if (bus.imem_gnt) begin m_req <= 1'b0; m_wait <= 1'b1; ph <= 0; end
            else ph <= ph + 1;
        end else if (m_wait) begin
            if (bus.imem_rvalid) begin
                m_wait <= 1'b0; m_valid <= 1'b1; m_instr <= bus.imem_rdata; ph <= 0;
            end
`ifdef FETCH_TIMEOUT_EN
            else if (ph + 1 >= TMO) begin
                m_wait <= 1'b0; m_err <= 1'b1; m_code <= 2'b11;
            end
`endif
            else ph <= ph + 1;
        end else if (m_valid) begin
            if (rdy) begin
                m_valid <= 1'b0; m_cnt <= m_cnt + 32'd1; ph <= 0;
                if (npc[1:0] != 2'b00) begin
                    m_err <= 1'b1; m_code <= 2'b01;
                end else if (npc < BASE || npc >= BASE + 4 * WORDS) begin
                    m_err <= 1'b1; m_code <= 2'b10;
                end else begin
                    m_pc <= npc; m_req <= 1'b1;
                end
            end else ph <= ph + 1;
        end
    end

    // Memory and decode responder, driven just after the falling edge
    always @(negedge clk) begin
        #1;
        bus.imem_gnt    = m_req && (ph >= gnt_dly);
        bus.imem_rvalid = rv_force || (m_wait && (ph >= rv_dly));
        bus.imem_rdata  = bus.imem_rvalid ? rdata_of(m_pc) : $urandom;
        rdy             = retire_en && m_valid && (ph >= rdy_dly);
        npc             = npc_fixed_en ? npc_fix : (m_pc + 32'd4);
    end

    // Per-cycle compare of every output against the model
    always @(negedge clk) begin
        chk("pc", pc, m_pc);
        chk("imem_addr", bus.imem_addr, m_pc);
        chk("imem_req", 32'(bus.imem_req), 32'(m_req));
        chk("instr_valid", 32'(instr_valid), 32'(m_valid));
        chk("instr", instr, m_instr);
        chk("fetch_err", 32'(fetch_err), 32'(m_err));
        chk("err_code", 32'(err_code), 32'(m_code));
        chk("retire_cnt", retire_cnt, m_cnt);
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        gnt_dly = 0; rv_dly = 0; rdy_dly = 0;
        retire_en = 1'b0; npc_fixed_en = 1'b0; rv_force = 1'b0; npc_fix = 32'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_cnt(input logic [31:0] n, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (m_cnt == n) begin
                n_chk++; n_pass++;
                return;
            end
        end
        n_chk++;
        $display("FAIL wait_retire: model count %0d, required %0d", m_cnt, n);
    endtask

    typedef struct { logic [31:0] npc; logic [1:0] code; } err_vec_t;
    err_vec_t err_tab[4];

    initial begin
        rst_n = 1'b0;
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
        rdy = 1'b0; npc = 32'h0;
        gnt_dly = 0; rv_dly = 0; rdy_dly = 0;
        retire_en = 1'b0; npc_fixed_en = 1'b0; rv_force = 1'b0; npc_fix = 32'h0;
        err_tab[0] = '{32'h0000_3002, 2'b01};
        err_tab[1] = '{32'h0000_2FFC, 2'b10};
        err_tab[2] = '{32'h0000_7000, 2'b10};
        err_tab[3] = '{32'h0000_2FFE, 2'b01};

        // First fetch at minimum latency, then ten retires at pc+4
        do_reset();
        chk("rst_pc", pc, 32'h0000_3000);
        chk("rst_retire", retire_cnt, 32'h0);
        retire_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("c2_valid", 32'(instr_valid), 32'h0);
        @(negedge clk);
        chk("c3_valid", 32'(instr_valid), 32'h1);
        chk("c3_instr", instr, 32'h3C01_1234);
        chk("c3_addr", bus.imem_addr, 32'h0000_3000);
        @(negedge clk);
        chk("ret1_pc", pc, 32'h0000_3004);
        chk("ret1_cnt", retire_cnt, 32'd1);
        repeat (26) @(negedge clk);
        chk("ret9_cnt", retire_cnt, 32'd9);
        @(negedge clk);
        chk("ret10_pc", pc, 32'h0000_3028);
        chk("ret10_cnt", retire_cnt, 32'd10);
        // Self-loop refetches the same word
        npc_fixed_en = 1'b1; npc_fix = 32'h0000_3028;
        wait_cnt(32'd12, 20);
        chk("loop_pc", pc, 32'h0000_3028);
        chk("loop_err", 32'(fetch_err), 32'h0);

        // Illegal next PCs: misalignment wins over range
        foreach (err_tab[k]) begin
            do_reset();
            retire_en = 1'b1; npc_fixed_en = 1'b1; npc_fix = err_tab[k].npc;
            wait_cnt(32'd1, 20);
            repeat (5) @(negedge clk);
            chk("err_flag", 32'(fetch_err), 32'h1);
            chk("err_code", 32'(err_code), 32'(err_tab[k].code));
            chk("err_pc", pc, 32'h0000_3000);
            chk("err_req", 32'(bus.imem_req), 32'h0);
            chk("err_cnt", retire_cnt, 32'd1);
        end

        // Last legal word is accepted
        do_reset();
        retire_en = 1'b1; npc_fixed_en = 1'b1; npc_fix = 32'h0000_6FFC;
        wait_cnt(32'd1, 20);
        retire_en = 1'b0;
        chk("top_pc", pc, 32'h0000_6FFC);
        chk("top_err", 32'(fetch_err), 32'h0);
        repeat (4) @(negedge clk);

        // Slow memory and slow decode
        do_reset();
        gnt_dly = 5; rv_dly = 7; rdy_dly = 4; retire_en = 1'b1;
        wait_cnt(32'd5, 200);
        retire_en = 1'b0;
        chk("slow_pc", pc, 32'h0000_3014);
        chk("slow_cnt", retire_cnt, 32'd5);

        // Reset during S_WAIT, stale rvalid right after release is ignored
        do_reset();
        rv_dly = 1000;
        repeat (4) @(negedge clk);
        chk("wait_req", 32'(bus.imem_req), 32'h0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1; gnt_dly = 3; rv_force = 1'b1;
        @(negedge clk);
        rv_force = 1'b0;
        chk("rel_req", 32'(bus.imem_req), 32'h1);
        chk("rel_pc", pc, 32'h0000_3000);
        chk("rel_valid", 32'(instr_valid), 32'h0);
        chk("rel_instr", instr, 32'h0);
        repeat (3) @(negedge clk);

        // gnt and rvalid together in S_REQ: data must come from a later rvalid
        do_reset();
        rv_dly = 3;
        @(negedge clk);
        rv_force = 1'b1;
        @(negedge clk);
        rv_force = 1'b0;
        chk("both_valid0", 32'(instr_valid), 32'h0);
        repeat (3) @(negedge clk);
        chk("both_valid1", 32'(instr_valid), 32'h0);
        @(negedge clk);
        chk("both_valid2", 32'(instr_valid), 32'h1);
        chk("both_instr", instr, 32'h3C01_1234);

        // No rvalid at all
        do_reset();
        rv_dly = 1000;
        repeat (102) @(negedge clk);
`ifdef FETCH_TIMEOUT_EN
        chk("tmo_err", 32'(fetch_err), 32'h1);
        chk("tmo_code", 32'(err_code), 32'h3);
        // rvalid on the limit cycle still captures
        do_reset();
        rv_dly = TMO - 1;
        repeat (2 + TMO) @(negedge clk);
        chk("tmo_edge_valid", 32'(instr_valid), 32'h1);
        chk("tmo_edge_err", 32'(fetch_err), 32'h0);
`else
        chk("notmo_err", 32'(fetch_err), 32'h0);
        chk("notmo_code", 32'(err_code), 32'h0);
        chk("notmo_valid", 32'(instr_valid), 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

endmodule
